// File: rtl/pc_status_unit_pkg.sv
// Shared definitions for the program-counter / status unit: opcodes, FSM states,
// status bit positions and the reset status word.
package pc_status_unit_pkg;

  typedef enum logic [2:0] {
    OP_NOP     = 3'd0,
    OP_JMP     = 3'd1,
    OP_JMPZ    = 3'd2,
    OP_JMPS    = 3'd3,
    OP_JMPZS   = 3'd4,
    OP_TRAP    = 3'd5,
    OP_RTT     = 3'd6,
    OP_SETMODE = 3'd7
  } op_e;

  typedef enum logic [1:0] {
    ST_RUN        = 2'd0,
    ST_TRAP_ENTRY = 2'd1,
    ST_TRAP       = 2'd2
  } state_e;

  localparam int BIT_Z    = 0;
  localparam int BIT_S    = 1;
  localparam int BIT_C    = 2;
  localparam int BIT_MODE = 3;
  localparam int BIT_TRAP = 4;

  localparam int STATUS_W = 13;
  localparam int PC_W     = 20;

  localparam logic [STATUS_W-1:0] STATUS_RESET = 13'h0008;

  // Conditional jumps look only at the flags held before the current edge.
  function automatic logic jump_taken(input op_e op, input logic z, input logic s);
    case (op)
      OP_JMP:   jump_taken = 1'b1;
      OP_JMPZ:  jump_taken = z;
      OP_JMPS:  jump_taken = s;
      OP_JMPZS: jump_taken = z & s;
      default:  jump_taken = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/pc_status_unit_status_bank.sv
// Status register storage. XOR writes take priority over ALU flag loads;
// mode and trap bits are applied on top of whichever of those happened.
module status_bank
  import pc_status_unit_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic                xstat_apply,
  input  logic [STATUS_W-1:0] xstat_bits,
  input  logic                flag_load,
  input  logic                alu_zero,
  input  logic                alu_sign,
  input  logic                alu_carry,
  input  logic                mode_load,
  input  logic                mode_val,
  input  logic                trap_set,
  input  logic                trap_clr,
  output logic [STATUS_W-1:0] status
);

  logic [STATUS_W-1:0] status_nxt;

  always_comb begin
    status_nxt = status;
    if (xstat_apply) begin
      status_nxt = status ^ xstat_bits;
    end else if (flag_load) begin
      status_nxt[BIT_Z] = alu_zero;
      status_nxt[BIT_S] = alu_sign;
      status_nxt[BIT_C] = alu_carry;
    end
    if (mode_load) begin
      status_nxt[BIT_MODE] = mode_val;
    end
    if (trap_set) begin
      status_nxt[BIT_TRAP] = 1'b1;
    end else if (trap_clr) begin
      status_nxt[BIT_TRAP] = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      status <= STATUS_RESET;
    end else begin
      status <= status_nxt;
    end
  end

endmodule

// File: rtl/pc_status_unit.sv
// Program counter, trap return address and trap sequencing FSM; status
// storage lives in status_bank.
//
// state         | meaning
// ST_RUN        | normal execution, accepts steps
// ST_TRAP_ENTRY | one-cycle trap entry bubble, steps ignored
// ST_TRAP       | trap handler running, accepts steps, RTT returns
module pc_status_unit
  import pc_status_unit_pkg::*;
#(
  parameter logic [19:0] TRAP_VECTOR = 20'h00010
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        step,
  input  logic [2:0]  op,
  input  logic [19:0] jmp_addr,
  input  logic        flag_we,
  input  logic        alu_zero,
  input  logic        alu_sign,
  input  logic        alu_carry,
  input  logic        mode_in,
  input  logic        xstat_we,
  input  logic [19:0] xstat_data,
  output logic [19:0] prog_point,
  output logic [12:0] status_reg,
  output logic        mode,
  output logic        trap_flag,
  output logic        ready
);

  state_e          state;
  logic [PC_W-1:0] epc;
  op_e             op_q;
  logic            accept;
  logic            in_trap;
  logic            xstat_apply;
  logic [PC_W-1:0] pc_inc;
  logic [PC_W-1:0] pc_next;
  logic            unused_xstat_hi;

  assign op_q        = op_e'(op);
  assign accept      = step & ready;
  assign in_trap     = (state == ST_TRAP);
  assign xstat_apply = xstat_we & in_trap;
  assign pc_inc      = prog_point + 20'd1;
  assign pc_next     = jump_taken(op_q, status_reg[BIT_Z], status_reg[BIT_S]) ? jmp_addr : pc_inc;
  assign unused_xstat_hi = ^xstat_data[19:13];

  status_bank u_status_bank (
    .clk         (clk),
    .rst         (rst),
    .xstat_apply (xstat_apply),
    .xstat_bits  (xstat_data[12:0]),
    .flag_load   (accept & flag_we & ~xstat_apply),
    .alu_zero    (alu_zero),
    .alu_sign    (alu_sign),
    .alu_carry   (alu_carry),
    .mode_load   (accept & (op_q == OP_SETMODE)),
    .mode_val    (mode_in),
    .trap_set    (accept & (op_q == OP_TRAP) & (state == ST_RUN)),
    .trap_clr    (accept & (op_q == OP_RTT) & in_trap),
    .status      (status_reg)
  );

  assign mode      = status_reg[BIT_MODE];
  assign trap_flag = status_reg[BIT_TRAP];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= ST_RUN;
      prog_point <= '0;
      epc        <= '0;
      ready      <= 1'b1;
    end else begin
      case (state)
        ST_RUN: begin
          if (accept) begin
            if (op_q == OP_TRAP) begin
              epc        <= pc_inc;
              prog_point <= TRAP_VECTOR;
              state      <= ST_TRAP_ENTRY;
              ready      <= 1'b0;
            end else begin
              prog_point <= pc_next;
            end
          end
        end
        ST_TRAP_ENTRY: begin
          state <= ST_TRAP;
          ready <= 1'b1;
        end
        ST_TRAP: begin
          if (accept) begin
            if (op_q == OP_RTT) begin
              prog_point <= epc;
              state      <= ST_RUN;
            end else begin
              // TRAP here is a plain NOP: no nesting, epc kept.
              prog_point <= pc_next;
            end
          end
        end
        default: begin
          state <= ST_RUN;
          ready <= 1'b1;
        end
      endcase
    end
  end

endmodule
